// File: rtl/oscillator_phase_pkg.sv
// -----------------------------------------------------------------------------
// Shared types for the pulse oscillator path.
//
//   CONFIG      : long_percent_t, the full-scale fraction type. Its width sets
//                 the phase accumulator width; full scale is one period.
//   OSCILLATOR  : oscillator_state_t (FRONT/BACK half of the pulse),
//                 osc_fsm_t with its state constants (IDLE/RUN/DRAIN) and the
//                 phase-vs-duty classification helper.
// -----------------------------------------------------------------------------
package CONFIG;

  // Unsigned fraction of full scale; 2^32 = 100 %.
  typedef logic [31:0] long_percent_t;

endpackage : CONFIG

package OSCILLATOR;

  // FRONT = phase below the duty threshold, BACK = at or above it.
  typedef enum logic {
    FRONT = 1'b0,
    BACK  = 1'b1
  } oscillator_state_t;

  // Voice gating FSM, kept as plain constants so older tools can use it.
  typedef logic [1:0] osc_fsm_t;

  localparam osc_fsm_t FSM_IDLE  = 2'd0;
  localparam osc_fsm_t FSM_RUN   = 2'd1;
  localparam osc_fsm_t FSM_DRAIN = 2'd2;

  // Strict less-than: duty 0 gives BACK for every phase, duty all-ones gives
  // FRONT for every phase except all-ones.
  function automatic oscillator_state_t classify_phase(
    input CONFIG::long_percent_t phase,
    input CONFIG::long_percent_t duty
  );
    return (phase < duty) ? FRONT : BACK;
  endfunction

endpackage : OSCILLATOR

// File: rtl/oscillator_phase_accumulator.sv
// -----------------------------------------------------------------------------
// phase_accumulator: modular phase register with adder and carry-out.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (register -> 0)
//   load        : register takes sum on the next edge
//   clear       : register takes 0 on the next edge (wins over load)
//   increment   : unsigned step added to the current value
//   sum         : current value + increment, mod 2^WIDTH (combinational)
//   carry       : carry out of that addition, i.e. the period wrapped
// -----------------------------------------------------------------------------
module phase_accumulator #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] increment,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  assign {carry, sum} = {1'b0, acc_q} + {1'b0, increment};

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (load) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule : phase_accumulator

// File: rtl/oscillator_phase.sv
// -----------------------------------------------------------------------------
// oscillator_phase: per-voice phase generator for the pulse oscillator.
//
// On every sample_tick the phase accumulator advances by `increment`, the new
// phase is classified FRONT/BACK against the latched duty, and the result is
// presented one cycle later. The gate FSM lets a released voice finish its
// current period (DRAIN) before going silent (IDLE).
//
// Optional feature macro: OSC_HARD_SYNC_EN adds the `sync` input (hard sync).
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   sample_tick  : one-cycle strobe at the audio sample rate (may repeat)
//   gate         : note active level
//   increment    : phase step per tick (frequency word), unsigned
//   duty         : FRONT fraction of the period, full scale = 100 %
//   sync         : hard-sync request (only with OSC_HARD_SYNC_EN)
//   state        : FRONT/BACK classification of phase
//   phase        : current phase
//   out_valid    : one-cycle strobe marking a new sample
//   wrap         : sample's accumulation overflowed, or a sync was applied
//   dbg_fsm      : current gate FSM state (observation only)
//
// Output protocol: out_valid is a pure strobe with no back-pressure; every
// tick produces exactly one out_valid pulse on the following cycle, and
// state/phase/wrap are meaningful only in that cycle (state/phase then hold,
// wrap returns to 0).
// -----------------------------------------------------------------------------
module oscillator_phase
  import CONFIG::*;
  import OSCILLATOR::*;
#(
  // Must equal $bits(long_percent_t).
  parameter int PHASE_WIDTH = $bits(long_percent_t)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_tick,
  input  logic                   gate,
  input  logic [PHASE_WIDTH-1:0] increment,
  input  long_percent_t          duty,
`ifdef OSC_HARD_SYNC_EN
  input  logic                   sync,
`endif
  output oscillator_state_t      state,
  output long_percent_t          phase,
  output logic                   out_valid,
  output logic                   wrap,
  output osc_fsm_t               dbg_fsm
);

  osc_fsm_t          fsm_q, fsm_d;
  long_percent_t     duty_q, duty_d;
  oscillator_state_t state_q, state_d;
  long_percent_t     phase_q, phase_d;
  logic              out_valid_q, out_valid_d;
  logic              wrap_q, wrap_d;

  logic              voice_active;
  logic              sync_fire;
  logic              acc_load;
  logic              acc_clear;
  logic [PHASE_WIDTH-1:0] acc_sum;
  logic              acc_carry;

  // Working values of the RUN/DRAIN tick.
  logic              wrap_now;
  long_percent_t     next_phase;
  long_percent_t     duty_eff;

  assign voice_active = (fsm_q == FSM_RUN) || (fsm_q == FSM_DRAIN);

  phase_accumulator #(
    .WIDTH (PHASE_WIDTH)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (acc_load),
    .clear     (acc_clear),
    .increment (increment),
    .sum       (acc_sum),
    .carry     (acc_carry)
  );

`ifdef OSC_HARD_SYNC_EN
  // A sync arriving between ticks is remembered until the next tick; a sync
  // in the same cycle as a tick is applied directly. Leaving RUN/DRAIN, or
  // any tick, clears the flag (the tick has consumed or discarded it).
  logic sync_pend_q, sync_pend_d;

  always_comb begin
    sync_fire   = sample_tick && voice_active && (sync_pend_q || sync);
    sync_pend_d = sync_pend_q;
    if (!voice_active || sample_tick) begin
      sync_pend_d = 1'b0;
    end else if (sync) begin
      sync_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pend_q <= 1'b0;
    end else begin
      sync_pend_q <= sync_pend_d;
    end
  end
`else
  always_comb begin
    sync_fire = 1'b0;
  end
`endif

  always_comb begin
    fsm_d       = fsm_q;
    duty_d      = duty_q;
    state_d     = state_q;
    phase_d     = phase_q;
    out_valid_d = 1'b0;
    wrap_d      = 1'b0;
    acc_load    = 1'b0;
    acc_clear   = 1'b0;
    wrap_now    = 1'b0;
    next_phase  = '0;
    duty_eff    = duty_q;

    if (sample_tick) begin
      out_valid_d = 1'b1;
      if (voice_active) begin
        // A sync acts as an immediate wrap to phase 0.
        wrap_now   = acc_carry || sync_fire;
        next_phase = sync_fire ? '0 : acc_sum;
        // Duty only changes at a period boundary, and the new value already
        // applies to the boundary sample itself.
        if (wrap_now) begin
          duty_eff = duty;
          duty_d   = duty;
        end
        acc_load  = 1'b1;
        acc_clear = sync_fire;
        wrap_d    = wrap_now;
        phase_d   = next_phase;
        state_d   = classify_phase(next_phase, duty_eff);

        if (fsm_q == FSM_RUN) begin
          if (!gate) begin
            fsm_d = FSM_DRAIN;
          end
        end else begin
          if (gate) begin
            // Re-trigger during release: keep running from the current phase.
            fsm_d = FSM_RUN;
          end else if (wrap_now || (increment == '0)) begin
            // Period finished (or can never finish): go silent at phase 0.
            fsm_d     = FSM_IDLE;
            acc_clear = 1'b1;
            phase_d   = '0;
            state_d   = FRONT;
          end
        end
      end else begin
        // IDLE (and recovery from any unused encoding).
        fsm_d     = FSM_IDLE;
        acc_clear = 1'b1;
        phase_d   = '0;
        state_d   = FRONT;
        if (gate) begin
          fsm_d   = FSM_RUN;
          duty_d  = duty;
          state_d = classify_phase('0, duty);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= FSM_IDLE;
      duty_q      <= '0;
      state_q     <= FRONT;
      phase_q     <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      duty_q      <= duty_d;
      state_q     <= state_d;
      phase_q     <= phase_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  assign state     = state_q;
  assign phase     = phase_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;
  assign dbg_fsm   = fsm_q;

endmodule : oscillator_phase

// File: tb/tb_oscillator_phase.sv
// -----------------------------------------------------------------------------
// Bench for oscillator_phase. Each tick pushes its hand-computed expected
// sample {fsm, wrap, state, phase} into exp_q; the monitor pops and compares
// on every out_valid. Define OSC_HARD_SYNC_EN to include the hard-sync cases.
// -----------------------------------------------------------------------------
module tb_oscillator_phase;
  import CONFIG::*;
  import OSCILLATOR::*;

  localparam int W = 36;
  localparam logic [31:0] Q1 = 32'h4000_0000;
  localparam logic [31:0] H  = 32'h8000_0000;
  localparam logic [31:0] Q3 = 32'hC000_0000;
  localparam logic [31:0] M1 = 32'hFFFF_FFFF;
  localparam logic F = 1'b0;
  localparam logic B = 1'b1;
  localparam logic [1:0] I = 2'd0;
  localparam logic [1:0] R = 2'd1;
  localparam logic [1:0] D = 2'd2;

  logic              clk;
  logic              rst_n;
  logic              sample_tick;
  logic              gate;
  logic [31:0]       increment;
  long_percent_t     duty;
  logic              sync;
  oscillator_state_t state;
  long_percent_t     phase;
  logic              out_valid;
  logic              wrap;
  osc_fsm_t          dbg_fsm;

  logic [W-1:0] exp_q[$];
  int n_compared;
  int n_failed;
  int n_sample;

  oscillator_phase dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .gate        (gate),
    .increment   (increment),
    .duty        (duty),
`ifdef OSC_HARD_SYNC_EN
    .sync        (sync),
`endif
    .state       (state),
    .phase       (phase),
    .out_valid   (out_valid),
    .wrap        (wrap),
    .dbg_fsm     (dbg_fsm)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] e(input logic [1:0] f, input logic w,
                                     input logic s, input logic [31:0] p);
    return {f, w, s, p};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    n_compared++;
    if (act !== req) begin
      n_failed++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_tick(input logic g, input logic [31:0] inc,
                         input logic [31:0] d, input logic [W-1:0] exp);
    gate        = g;
    increment   = inc;
    duty        = d;
    sample_tick = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        n_sample++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {35'd0, out_valid}, '0);
        end else begin
          check($sformatf("sample%0d", n_sample),
                {dbg_fsm, wrap, state, phase}, exp_q.pop_front());
        end
      end else begin
        check("wrap_without_valid", {35'd0, wrap}, '0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_compared  = 0;
    n_failed    = 0;
    n_sample    = 0;
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    gate        = 1'b0;
    increment   = '0;
    duty        = '0;
    sync        = 1'b0;

    #2;
    check("reset_outputs", {dbg_fsm, wrap, state, phase}, e(I, 1'b0, F, 32'h0));
    check("reset_valid", {35'd0, out_valid}, '0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Basic period.
    do_tick(1, Q1, H, e(R, 0, F, 32'h0));
    do_tick(1, Q1, H, e(R, 0, F, Q1));
    do_tick(1, Q1, H, e(R, 0, B, H));
    do_tick(1, Q1, H, e(R, 0, B, Q3));
    do_tick(1, Q1, H, e(R, 1, F, 32'h0));
    idle(2);

    // Duty deferral: new duty Q1 only takes effect at the wrap.
    do_tick(1, Q1, Q1, e(R, 0, F, Q1));
    do_tick(1, Q1, Q1, e(R, 0, B, H));
    do_tick(1, Q1, Q1, e(R, 0, B, Q3));
    do_tick(1, Q1, Q1, e(R, 1, F, 32'h0));
    do_tick(1, Q1, Q1, e(R, 0, B, Q1));
    idle(1);

    // Release at phase Q1: drain to the end of the period, then IDLE.
    do_tick(0, Q1, Q1, e(D, 0, B, H));
    do_tick(0, Q1, Q1, e(D, 0, B, Q3));
    do_tick(0, Q1, Q1, e(I, 1, F, 32'h0));
    do_tick(0, Q1, Q1, e(I, 0, F, 32'h0));
    idle(1);

    // Re-raise gate during DRAIN: phase continues, no reset.
    do_tick(1, Q1, H, e(R, 0, F, 32'h0));
    do_tick(0, Q1, H, e(D, 0, F, Q1));
    do_tick(1, Q1, H, e(R, 0, B, H));
    do_tick(1, Q1, H, e(R, 0, B, Q3));
    do_tick(1, Q1, H, e(R, 1, F, 32'h0));

    // Zero increment while draining ends the drain immediately.
    do_tick(0, 32'h0, H, e(D, 0, F, 32'h0));
    do_tick(0, 32'h0, H, e(I, 0, F, 32'h0));
    idle(2);

    // Back-to-back ticks, increment all-ones, duty 0 (always BACK).
    do_tick(1, M1, 32'h0, e(R, 0, B, 32'h0));
    do_tick(1, M1, 32'h0, e(R, 0, B, 32'hFFFF_FFFF));
    do_tick(1, M1, 32'h0, e(R, 1, B, 32'hFFFF_FFFE));
    do_tick(1, M1, 32'h0, e(R, 1, B, 32'hFFFF_FFFD));
    do_tick(1, M1, 32'h0, e(R, 1, B, 32'hFFFF_FFFC));

    // Duty all-ones: FRONT except at phase all-ones.
    do_tick(1, 32'h3, M1, e(R, 0, B, 32'hFFFF_FFFF));
    do_tick(1, 32'h1, M1, e(R, 1, F, 32'h0));
    do_tick(1, 32'hFFFF_FFFE, M1, e(R, 0, F, 32'hFFFF_FFFE));
    do_tick(1, 32'h1, M1, e(R, 0, B, 32'hFFFF_FFFF));
    idle(3);

    // Asynchronous reset mid-RUN.
    #3;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {dbg_fsm, wrap, state, phase}, e(I, 1'b0, F, 32'h0));
    check("midrun_reset_valid", {35'd0, out_valid}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    do_tick(0, Q1, H, e(I, 0, F, 32'h0));
    idle(1);

`ifdef OSC_HARD_SYNC_EN
    // Sync at phase H, tick two cycles later: phase 0, wrap, duty reloaded.
    do_tick(1, Q1, H, e(R, 0, F, 32'h0));
    do_tick(1, Q1, H, e(R, 0, F, Q1));
    do_tick(1, Q1, H, e(R, 0, B, H));
    sync = 1'b1;
    @(posedge clk);
    #1;
    sync = 1'b0;
    do_tick(1, Q1, Q1, e(R, 1, F, 32'h0));
    do_tick(1, Q1, Q1, e(R, 0, B, Q1));
    // Same-cycle sync in DRAIN completes the drain.
    do_tick(0, Q1, Q1, e(D, 0, B, H));
    sync = 1'b1;
    do_tick(0, Q1, Q1, e(I, 1, F, 32'h0));
    sync = 1'b0;
    // Sync in IDLE is ignored and leaves nothing pending.
    sync = 1'b1;
    @(posedge clk);
    #1;
    sync = 1'b0;
    do_tick(0, Q1, H, e(I, 0, F, 32'h0));
    do_tick(1, Q1, H, e(R, 0, F, 32'h0));
    do_tick(1, Q1, H, e(R, 0, F, Q1));
    idle(1);
`endif

    idle(4);
    check("queue_drained", W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule : tb_oscillator_phase
